pc_fetch_sequencer: RTL and testbench

//  Owns the program counter and sequences instruction fetch: drives the PC and the
//  PC+4 incrementor, holds each imem request until it is acknowledged, applies

---
 rtl/pc_fetch_sequencer.sv | 87 ++++++++
 tb/tb_pc_fetch_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and instruction-fetch sequencer: holds each imem request until acked,
// applies branch/jump redirects and stalls, and flags IF/ID flush.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic        ImemReady,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    output logic [31:0] PCPlus4,
    output logic        FetchValid,
    output logic        Flush,
    output logic [31:0] FetchCount
);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pend_target;
    logic [31:0] r_fetch_count;

    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_active;

    // The EX branch is older than the ID jump, so it wins when both fire.
    assign w_redirect = BranchTaken | Jump;
    assign w_target   = (BranchTaken ? BranchTarget : JumpTarget) & 32'hFFFF_FFFC;
    assign w_active   = !Reset && ((r_state == ST_FETCH) || (r_state == ST_DRAIN));

    assign ImemReq    = w_active;
    assign ImemAddr   = r_pc;
    assign PCPlus4    = r_pc + 32'd4;
    assign Flush      = w_active && w_redirect;
    assign FetchValid = !Reset && (r_state == ST_FETCH) && ImemReady && !w_redirect && !Stall;
    assign FetchCount = r_fetch_count;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state       <= ST_BOOT;
            r_pc          <= RESET_PC;
            r_pend_target <= 32'd0;
            r_fetch_count <= 32'd0;
        end else begin
            r_fetch_count <= r_fetch_count + {31'd0, FetchValid};
            case (r_state)
                ST_BOOT: begin
                    r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (ImemReady) begin
                        if (w_redirect) begin
                            r_pc <= w_target;
                        end else if (!Stall) begin
                            r_pc <= PCPlus4;
                        end
                    end else if (w_redirect) begin
                        // Request address must stay stable until acked; park the target.
                        r_pend_target <= w_target;
                        r_state       <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (ImemReady) begin
                        r_pc    <= w_redirect ? w_target : r_pend_target;
                        r_state <= ST_FETCH;
                    end else if (w_redirect) begin
                        r_pend_target <= w_target;
                    end
                end
                default: begin
                    r_state <= ST_BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: a directed vector table, corner-case sequences,
// and random stimulus checked against a behavioural fetch model.
module tb_pc_fetch_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0400;
    localparam int          NTBL   = 19;

    logic        Clk;
    logic        Reset;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic        ImemReady;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic [31:0] PCPlus4;
    logic        FetchValid;
    logic        Flush;
    logic [31:0] FetchCount;

    int n_vec = 0;
    int n_err = 0;

    pc_fetch_sequencer #(.RESET_PC(RST_PC)) dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .Jump(Jump), .JumpTarget(JumpTarget), .ImemReady(ImemReady),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr), .PCPlus4(PCPlus4),
        .FetchValid(FetchValid), .Flush(Flush), .FetchCount(FetchCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] bt;
        logic        jmp;
        logic [31:0] jt;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_fv;
        logic        e_fl;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl [NTBL];

    // Behavioural model: where fetch is, whether a request is orphaned, what comes next.
    logic [31:0] m_pc;
    logic [31:0] m_pend;
    logic [31:0] m_cnt;
    logic        m_boot;
    logic        m_waiting_old;
    logic        m_known;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic stall, input logic br, input logic [31:0] bt,
                         input logic jmp, input logic [31:0] jt, input logic rdy);
        Reset        = rst;
        Stall        = stall;
        BranchTaken  = br;
        BranchTarget = bt;
        Jump         = jmp;
        JumpTarget   = jt;
        ImemReady    = rdy;
    endtask

    function automatic vec_t mk(input logic rst, input logic stall, input logic br,
                                input logic [31:0] bt, input logic jmp, input logic [31:0] jt,
                                input logic rdy, input logic e_req, input logic [31:0] e_addr,
                                input logic e_fv, input logic e_fl, input logic [31:0] e_cnt);
        vec_t v;
        v.rst = rst; v.stall = stall; v.br = br; v.bt = bt; v.jmp = jmp; v.jt = jt; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_fv = e_fv; v.e_fl = e_fl; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic tstep(input vec_t v, input int idx);
        drive(v.rst, v.stall, v.br, v.bt, v.jmp, v.jt, v.rdy);
        #2;
        chk($sformatf("tbl%0d.req", idx),  32'(ImemReq),    32'(v.e_req));
        chk($sformatf("tbl%0d.addr", idx), ImemAddr,        v.e_addr);
        chk($sformatf("tbl%0d.pc4", idx),  PCPlus4,         v.e_addr + 32'd4);
        chk($sformatf("tbl%0d.fv", idx),   32'(FetchValid), 32'(v.e_fv));
        chk($sformatf("tbl%0d.fl", idx),   32'(Flush),      32'(v.e_fl));
        chk($sformatf("tbl%0d.cnt", idx),  FetchCount,      v.e_cnt);
        @(posedge Clk);
        #1;
    endtask

    task automatic mstep(input string tag, input logic rst, input logic stall, input logic br,
                         input logic [31:0] bt, input logic jmp, input logic [31:0] jt,
                         input logic rdy);
        logic        redir;
        logic [31:0] tgt;
        logic        e_req;
        logic        e_fv;
        logic        e_fl;
        redir = br | jmp;
        tgt   = (br ? bt : jt) & ~32'd3;
        e_req = !rst && !m_boot;
        e_fl  = e_req && redir;
        e_fv  = e_req && !m_waiting_old && rdy && !redir && !stall;
        drive(rst, stall, br, bt, jmp, jt, rdy);
        #2;
        chk({tag, ".req"}, 32'(ImemReq),    32'(e_req));
        chk({tag, ".fv"},  32'(FetchValid), 32'(e_fv));
        chk({tag, ".fl"},  32'(Flush),      32'(e_fl));
        if (m_known) begin
            chk({tag, ".addr"}, ImemAddr,   m_pc);
            chk({tag, ".pc4"},  PCPlus4,    m_pc + 32'd4);
            chk({tag, ".cnt"},  FetchCount, m_cnt);
        end
        @(posedge Clk);
        #1;
        if (rst) begin
            m_pc = RST_PC; m_pend = 32'd0; m_cnt = 32'd0;
            m_boot = 1'b1; m_waiting_old = 1'b0; m_known = 1'b1;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else begin
            m_cnt = m_cnt + 32'(e_fv);
            if (m_waiting_old) begin
                if (rdy) begin
                    m_pc = redir ? tgt : m_pend;
                    m_waiting_old = 1'b0;
                end else if (redir) begin
                    m_pend = tgt;
                end
            end else if (rdy) begin
                if (redir) m_pc = tgt;
                else if (!stall) m_pc = m_pc + 32'd4;
            end else if (redir) begin
                m_pend = tgt;
                m_waiting_old = 1'b1;
            end
        end
    endtask

    initial begin
        m_pc = '0; m_pend = '0; m_cnt = '0;
        m_boot = 1'b1; m_waiting_old = 1'b0; m_known = 1'b0;

        //          rst   stall br    bt             jmp   jt             rdy   req   addr           fv    fl    cnt
        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h0000_0400, 1'b0, 1'b0, 32'd0);
        tbl[1]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h0000_0400, 1'b0, 1'b0, 32'd0);
        tbl[2]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0400, 1'b1, 1'b0, 32'd0);
        tbl[3]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0404, 1'b1, 1'b0, 32'd1);
        tbl[4]  = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0408, 1'b0, 1'b0, 32'd2);
        tbl[5]  = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0408, 1'b0, 1'b0, 32'd2);
        tbl[6]  = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0408, 1'b0, 1'b0, 32'd2);
        tbl[7]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0408, 1'b1, 1'b0, 32'd2);
        tbl[8]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_040C, 1'b1, 1'b0, 32'd3);
        tbl[9]  = mk(1'b0, 1'b0, 1'b1, 32'h0000_1000, 1'b0, 32'h0,       1'b1, 1'b1, 32'h0000_0410, 1'b0, 1'b1, 32'd4);
        tbl[10] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_1000, 1'b1, 1'b0, 32'd4);
        tbl[11] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_1004, 1'b0, 1'b0, 32'd5);
        tbl[12] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_2002, 1'b0, 1'b1, 32'h0000_1004, 1'b0, 1'b1, 32'd5);
        tbl[13] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_1004, 1'b0, 1'b0, 32'd5);
        tbl[14] = mk(1'b0, 1'b0, 1'b1, 32'h0000_3000, 1'b0, 32'h0,       1'b0, 1'b1, 32'h0000_1004, 1'b0, 1'b1, 32'd5);
        tbl[15] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_1004, 1'b0, 1'b0, 32'd5);
        tbl[16] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_3000, 1'b1, 1'b0, 32'd5);
        tbl[17] = mk(1'b0, 1'b0, 1'b1, 32'h0000_5000, 1'b1, 32'h0000_6000, 1'b1, 1'b1, 32'h0000_3004, 1'b0, 1'b1, 32'd6);
        tbl[18] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_5000, 1'b1, 1'b0, 32'd6);

        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        @(posedge Clk);
        #1;
        for (int i = 0; i < NTBL; i++) tstep(tbl[i], i);

        // Wrap-around of the PC at the top of the address space.
        mstep("t5.rst",  1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        mstep("t5.boot", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        mstep("t5.br",   1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b1);
        chk("t5.top",  ImemAddr, 32'hFFFF_FFFC);
        chk("t5.pc4",  PCPlus4,  32'h0000_0000);
        mstep("t5.ack",  1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("t5.wrap", ImemAddr, 32'h0000_0000);

        // Reset while draining an orphaned request drops the pending target.
        mstep("t6.jmp",  1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_7000, 1'b0);
        mstep("t6.wait", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        mstep("t6.rst",  1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t6.req",  32'(ImemReq), 32'd0);
        chk("t6.pc",   ImemAddr, RST_PC);
        chk("t6.cnt",  FetchCount, 32'd0);
        mstep("t6.boot", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        mstep("t6.f0",   1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("t6.next", ImemAddr, RST_PC + 32'd4);

        for (int i = 0; i < 2000; i++) begin
            mstep("rnd",
                  1'(($urandom % 64) == 0),
                  1'(($urandom % 4) == 0),
                  1'(($urandom % 8) == 0), $urandom,
                  1'(($urandom % 8) == 0), $urandom,
                  1'(($urandom % 2) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
